// File: rtl/fft_input_loader.sv
// fft_input_loader
// Collects eight serial samples into a parallel frame for the first
// butterfly stage of an 8-point FFT. Sample k of a frame is stored in
// slot bitrev3(k), so the frame leaves in bit-reversed order.
// A sample flagged as last before the eighth one aborts the frame:
// that sample is dropped, the frame restarts and err pulses for one cycle.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : asynchronous reset, active low
//   in_data   : serial sample (WIDTH bits, two's complement)
//   in_valid  : in_data is valid
//   in_last   : sample is the last of a frame
//   in_ready  : loader accepts a sample this cycle (registered)
//   out_data  : parallel frame, slot j at [j*WIDTH +: WIDTH]
//   out_valid : out_data holds a complete frame (registered)
//   out_ready : downstream stage takes the frame
//   err       : one-cycle pulse after a short frame (registered)
module fft_input_loader #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    // N only documents the fixed-point format shared with later stages;
    // it is folded in here so it is referenced without affecting anything.
    localparam int SLOTS = 8 + (N - N);

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_s;
    logic   [2:0]                  cnt_r;
    logic   [SLOTS-1:0][WIDTH-1:0] slot_r;
    logic                          in_ready_r;
    logic                          out_valid_r;
    logic                          err_r;
    logic                          accept_s;
    logic                          short_s;
    logic                          store_s;

    // Bit-reversed slot index for a 3-bit sample position.
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Handshake decode and next-state selection.
    always_comb begin
        state_s  = state_r;
        accept_s = (state_r == LOAD) && in_valid && in_ready_r;
        short_s  = accept_s && in_last && (cnt_r != 3'd7);
        store_s  = accept_s && !short_s;
        case (state_r)
            LOAD: begin
                if (store_s && (cnt_r == 3'd7)) begin
                    state_s = HOLD;
                end else begin
                    state_s = LOAD;
                end
            end
            HOLD: begin
                if (out_valid_r && out_ready) begin
                    state_s = LOAD;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // State, counter and registered handshake/error outputs. in_ready is
    // derived from the next state so it rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= LOAD;
            cnt_r       <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == LOAD);
            out_valid_r <= (state_s == HOLD);
            err_r       <= short_s;
            if (short_s) begin
                cnt_r <= 3'd0;
            end else if (store_s) begin
                cnt_r <= cnt_r + 3'd1;   // wraps to 0 after sample 7
            end
        end
    end

    // Slot storage; an aborted frame leaves stale slots that the next
    // frame overwrites completely before out_valid can rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r <= '0;
        end else if (store_s) begin
            slot_r[bitrev3(cnt_r)] <= in_data;
        end
    end

    assign out_data  = slot_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: directed scenarios followed by
// random traffic, compared against a queue-based frame model.
module tb_fft_input_loader;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic [8*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: accepted samples of the current frame, plus the
    // expected registered outputs.
    logic [W-1:0]   m_q[$];
    logic [8*W-1:0] m_frame = '0;
    logic           m_hold  = 1'b0;
    logic           m_rdy   = 1'b0;
    logic           m_err   = 1'b0;

    fft_input_loader #(.WIDTH(W), .N(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int rev3(input int k);
        int r = 0;
        for (int i = 0; i < 3; i++) if ((k >> i) & 1) r += 1 << (2 - i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_frame = '0;
        m_hold  = 1'b0;
        m_rdy   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        m_err = 1'b0;
        if (!m_hold) begin
            if (m_rdy && v) begin
                if (l && m_q.size() < 7) begin
                    m_q.delete();
                    m_err = 1'b1;
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == 8) begin
                        for (int j = 0; j < 8; j++) m_frame[j*W +: W] = m_q[rev3(j)];
                        m_q.delete();
                        m_hold = 1'b1;
                    end
                end
            end
        end else if (r) begin
            m_hold = 1'b0;
        end
        m_rdy = !m_hold;
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
        cyc++;
        model_step(v, d, l, r);
        chk("in_ready", {127'd0, in_ready}, {127'd0, m_rdy});
        chk("out_valid", {127'd0, out_valid}, {127'd0, m_hold});
        chk("err", {127'd0, err}, {127'd0, m_err});
        if (m_hold) chk("out_data", out_data, m_frame);
    endtask

    // Present one sample until the model says it was taken.
    task automatic send(input logic [W-1:0] d, input logic l, input logic r);
        int n = 0;
        logic taken;
        taken = 1'b0;
        while (!taken && n < 50) begin
            taken = m_rdy && !m_hold;
            cycle(1'b1, d, l, r);
            n++;
        end
        if (!taken) chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, r);
    endtask

    // Assert reset between edges, check outputs clear at once, then release.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #2;
        chk("init_in_ready", {127'd0, in_ready}, 128'd0);
        chk("init_out_valid", {127'd0, out_valid}, 128'd0);
        chk("init_out_data", out_data, 128'd0);
        #20;
        rst = 1'b1;
        cyc = 0;

        // Full frame, out_ready tied high.
        idle(1, 1'b1);
        chk("rdy_after_release", {127'd0, in_ready}, 128'd1);
        for (int k = 0; k < 8; k++) send(16'(k * 16'h0010), k == 7, 1'b1);
        chk("frame1_exact", out_data,
            {16'h0070, 16'h0030, 16'h0050, 16'h0010, 16'h0060, 16'h0020, 16'h0040, 16'h0000});
        idle(2, 1'b1);

        // Backpressure: held for 5 cycles with in_valid pulses ignored.
        for (int k = 0; k < 8; k++) send(16'(k * 16'h0010), k == 7, 1'b0);
        for (int i = 0; i < 5; i++) cycle(i[0], 16'hDEAD, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("bp_release_rdy", {127'd0, in_ready}, 128'd1);

        // Short frame, then a clean frame of 0x0100..0x0107.
        for (int k = 0; k < 4; k++) send(16'(16'h0A00 + k), k == 3, 1'b1);
        idle(1, 1'b1);
        for (int k = 0; k < 8; k++) send(16'(16'h0100 + k), 1'b0, 1'b1);
        chk("short_recover", out_data,
            {16'h0107, 16'h0103, 16'h0105, 16'h0101, 16'h0106, 16'h0102, 16'h0104, 16'h0100});
        idle(1, 1'b1);

        // in_valid toggling: frame arrives after 15 cycles.
        cyc = 0;
        for (int i = 0; i < 15; i++) cycle(!i[0], 16'((i / 2) * 16'h0010), 1'b0, 1'b0);
        chk("gap_cycle15", {127'd0, out_valid}, 128'd1);
        idle(1, 1'b1);

        // Reset after 5 samples, then 0xFFF0..0xFFF7.
        for (int k = 0; k < 5; k++) send(16'(16'h1230 + k), 1'b0, 1'b1);
        do_reset();
        idle(1, 1'b1);
        for (int k = 0; k < 8; k++) send(16'(16'hFFF0 + k), 1'b0, 1'b1);
        chk("post_rst_frame", out_data,
            {16'hFFF7, 16'hFFF3, 16'hFFF5, 16'hFFF1, 16'hFFF6, 16'hFFF2, 16'hFFF4, 16'hFFF0});

        // Back-to-back frames: out_valid exactly at cycles 9, 18, 27.
        do_reset();
        for (int i = 1; i <= 27; i++) begin
            cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
            chk("b2b_timing", {127'd0, out_valid}, {127'd0, (i % 9) == 0});
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
